lift_req_queue: RTL and testbench



---
 rtl/lift_pkg.sv | 49 ++++
 rtl/lift_req_queue_if.sv | 13 +
 rtl/lift_req_fifo.sv | 53 +++++
 rtl/lift_req_queue.sv | 75 +++++++
 tb/tb_lift_req_queue.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared request/action encodings for the lift request path
// Request codes match the LiftFSM input encoding; btn2code/code2mask map button index <-> code.
package lift_pkg;
  typedef logic [2:0] req_code_t;

  localparam req_code_t REQ_NONE = 3'b000;
  localparam req_code_t REQ_1U   = 3'b001;
  localparam req_code_t REQ_2U   = 3'b010;
  localparam req_code_t REQ_3U   = 3'b011;
  localparam req_code_t REQ_2D   = 3'b110;
  localparam req_code_t REQ_3D   = 3'b111;
  localparam req_code_t REQ_4D   = 3'b100;

  localparam int BTN_1U  = 0;
  localparam int BTN_2U  = 1;
  localparam int BTN_3U  = 2;
  localparam int BTN_2D  = 3;
  localparam int BTN_3D  = 4;
  localparam int BTN_4D  = 5;
  localparam int NUM_BTN = 6;

  localparam logic [1:0] ACT_STAY = 2'b00;
  localparam logic [1:0] ACT_UP   = 2'b01;
  localparam logic [1:0] ACT_DOWN = 2'b10;

  function automatic req_code_t btn2code(input logic [2:0] idx);
    case (idx)
      3'd0:    return REQ_1U;
      3'd1:    return REQ_2U;
      3'd2:    return REQ_3U;
      3'd3:    return REQ_2D;
      3'd4:    return REQ_3D;
      3'd5:    return REQ_4D;
      default: return REQ_NONE;
    endcase
  endfunction

  function automatic logic [5:0] code2mask(input req_code_t code);
    case (code)
      REQ_1U:  return 6'b000001;
      REQ_2U:  return 6'b000010;
      REQ_3U:  return 6'b000100;
      REQ_2D:  return 6'b001000;
      REQ_3D:  return 6'b010000;
      REQ_4D:  return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction
endpackage

// File: rtl/lift_req_queue_if.sv
// rtl/lift_req_queue_if.sv - button/done inputs and queue status outputs of lift_req_queue
// master drives buttons and done; slave is the request queue.
interface lift_req_queue_if;
  logic [5:0] btn;
  logic       done;
  logic [2:0] din;
  logic       qEmpty;
  logic       full;
  logic [5:0] pending;

  modport master (output btn, done, input din, qEmpty, full, pending);
  modport slave  (input btn, done, output din, qEmpty, full, pending);
endinterface

// File: rtl/lift_req_fifo.sv
// rtl/lift_req_fifo.sv - synchronous FIFO with a registered head output
// head is reloaded on push-into-empty and on pop, so it never reads the write port combinationally.
module lift_req_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_next;
  logic             do_push;
  logic             do_pop;

  assign rd_next = rd_ptr + 1'b1;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_next;
        // More than one entry left means the next head already sits in mem.
        if (rd_next != wr_ptr) head <= mem[rd_next[AW-1:0]];
        else if (do_push)      head <= wdata;
        else                   head <= '0;
      end else if (empty && do_push) begin
        head <= wdata;
      end
    end
  end
endmodule

// File: rtl/lift_req_queue.sv
// rtl/lift_req_queue.sv - hall-call capture, dedup and arrival-order queue feeding LiftFSM
// lat holds captured calls awaiting a slot; inq marks calls already in the FIFO.
module lift_req_queue
  import lift_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  lift_req_queue_if.slave bus
);
  logic [5:0] btn_q;
  logic       done_q;
  logic [5:0] lat;
  logic [5:0] inq;
  logic [5:0] rise;
  logic [5:0] sel_mask;
  logic [5:0] push_mask;
  logic [5:0] pop_mask;
  logic [2:0] sel_idx;
  req_code_t  head;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  assign rise     = bus.btn & ~btn_q;
  assign sel_mask = lat & (~lat + 6'd1);

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (lat[i]) sel_idx = 3'(i);
    end
  end

  assign pop       = bus.done && !done_q && !empty;
  assign push      = (|lat) && (!full || pop);
  assign push_mask = push ? sel_mask : 6'b0;
  assign pop_mask  = pop ? code2mask(head) : 6'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q  <= '0;
      done_q <= 1'b0;
      lat    <= '0;
      inq    <= '0;
    end else begin
      btn_q  <= bus.btn;
      done_q <= bus.done;
      // Dedup uses pre-update lat/inq, so a call popping this cycle still blocks its own re-press.
      lat    <= (lat & ~push_mask) | (rise & ~lat & ~inq);
      inq    <= (inq & ~pop_mask) | push_mask;
    end
  end

  lift_req_fifo #(
    .WIDTH (3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (btn2code(sel_idx)),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign bus.din     = head;
  assign bus.qEmpty  = empty;
  assign bus.full    = full;
  assign bus.pending = lat | inq;
endmodule

// File: tb/tb_lift_req_queue.sv
// tb/tb_lift_req_queue.sv - scoreboard bench for lift_req_queue with DEPTH=4
// Stimulus queues expected codes; the monitor checks din on every accepted done rise.
module tb_lift_req_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_pops = 0;
  logic done_prev = 1'b0;
  logic [2:0] exp_q[$];

  lift_req_queue_if bus();

  lift_req_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (bus.done && !done_prev && !bus.qEmpty) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %0h expected no entry", bus.din);
        end else begin
          check("pop_order", 32'(bus.din), 32'(exp_q.pop_front()));
        end
      end
      done_prev = bus.done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn  = 6'h3F;
    bus.done = 1'b0;
    repeat (3) tick();
    check("rst_din", 32'(bus.din), 0);
    check("rst_qempty", 32'(bus.qEmpty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_pending", 32'(bus.pending), 0);

    // Buttons already high at reset release count as six simultaneous presses.
    rst_n = 1'b1;
    exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b011);
    exp_q.push_back(3'b110); exp_q.push_back(3'b111); exp_q.push_back(3'b100);
    tick();
    check("all_latched_pending", 32'(bus.pending), 32'h3F);
    check("all_latched_qempty", 32'(bus.qEmpty), 1);
    bus.btn = 6'h00;
    tick();
    check("first_push_din", 32'(bus.din), 32'h1);
    repeat (3) tick();
    check("full_after_4", 32'(bus.full), 1);
    check("full_pending", 32'(bus.pending), 32'h3F);
    for (int i = 0; i < 6; i++) begin
      bus.done = 1'b1;
      tick();
      check("full_during_pops", 32'(bus.full), (i < 2) ? 1 : 0);
      bus.done = 1'b0;
      tick();
    end
    check("drained_qempty", 32'(bus.qEmpty), 1);
    check("drained_din", 32'(bus.din), 0);
    check("drained_pending", 32'(bus.pending), 0);

    bus.btn = 6'h04;
    exp_q.push_back(3'b011);
    tick();
    check("single_pending", 32'(bus.pending), 32'h04);
    check("single_qempty_1edge", 32'(bus.qEmpty), 1);
    bus.btn = 6'h00;
    tick();
    check("single_din", 32'(bus.din), 32'h3);
    check("single_qempty_2edge", 32'(bus.qEmpty), 0);
    bus.done = 1'b1;
    tick();
    check("single_pop_din", 32'(bus.din), 0);
    check("single_pop_qempty", 32'(bus.qEmpty), 1);
    check("single_pop_pending", 32'(bus.pending), 0);
    bus.done = 1'b0;
    tick();

    bus.btn = 6'h20;
    exp_q.push_back(3'b100);
    tick();
    bus.btn = 6'h00;
    tick();
    bus.btn = 6'h20;
    tick();
    bus.btn = 6'h00;
    tick();
    check("dedup_pending", 32'(bus.pending), 32'h20);
    check("dedup_din", 32'(bus.din), 32'h4);
    bus.done = 1'b1;
    tick();
    check("dedup_one_entry", 32'(bus.qEmpty), 1);
    bus.done = 1'b0;
    tick();

    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    check("empty_done_qempty", 32'(bus.qEmpty), 1);
    check("empty_done_din", 32'(bus.din), 0);
    check("empty_done_pending", 32'(bus.pending), 0);

    bus.btn = 6'h07;
    exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b011);
    tick();
    bus.btn = 6'h00;
    repeat (3) tick();
    bus.done = 1'b1;
    repeat (5) tick();
    check("hold_done_din", 32'(bus.din), 32'h2);
    check("hold_done_pending", 32'(bus.pending), 32'h06);
    bus.done = 1'b0;
    tick();

    // Re-press 2U in the very cycle its entry pops: must be ignored.
    bus.done = 1'b1;
    bus.btn  = 6'h02;
    tick();
    bus.done = 1'b0;
    bus.btn  = 6'h00;
    repeat (2) tick();
    check("pop_press_din", 32'(bus.din), 32'h3);
    check("pop_press_pending", 32'(bus.pending), 32'h04);

    bus.btn = 6'h18;
    exp_q.push_back(3'b110); exp_q.push_back(3'b111);
    tick();
    bus.btn = 6'h00;
    repeat (2) tick();
    check("pre_reset_pending", 32'(bus.pending), 32'h1C);
    check("pre_reset_qempty", 32'(bus.qEmpty), 0);

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_din", 32'(bus.din), 0);
    check("async_qempty", 32'(bus.qEmpty), 1);
    check("async_full", 32'(bus.full), 0);
    check("async_pending", 32'(bus.pending), 0);
    exp_q.delete();
    check("pop_count", 32'(n_pops), 10);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
